// File: rtl/fb_pkg.sv
// Shared types and constants for the LED panel framebuffer write controller.
package fb_pkg;

    localparam int unsigned FB_ADDR_W = 12;
    localparam int unsigned FB_DATA_W = 24;

    // Bit positions inside the control PIO word.
    localparam int unsigned CTRL_COMMIT  = 0;
    localparam int unsigned CTRL_AUTOINC = 1;
    localparam int unsigned CTRL_OVFCLR  = 2;

    // Status word layout: {11'b0, overflow, busy, fifo_level[2:0], wr_count[15:0]}.
    localparam int unsigned STAT_WRCNT_LSB = 0;
    localparam int unsigned STAT_WRCNT_W   = 16;
    localparam int unsigned STAT_LEVEL_LSB = 16;
    localparam int unsigned STAT_LEVEL_W   = 3;
    localparam int unsigned STAT_BUSY      = 19;
    localparam int unsigned STAT_OVF       = 20;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [FB_DATA_W-1:0] data;
    } fb_cmd_t;

endpackage

// File: rtl/fb_write_ctrl_fifo.sv
// Small synchronous FIFO of framebuffer write commands. Push while full is only
// accepted when a pop happens in the same cycle.
module fb_cmd_fifo
    import fb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  fb_cmd_t          wdata,
    input  logic             pop,
    output fb_cmd_t          rdata,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fb_cmd_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push, do_pop;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q];
    assign level   = level_q;

    // Pointers and fill level; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      level_q <= level_q + 1'b1;
            else if (do_pop && !do_push) level_q <= level_q - 1'b1;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/fb_write_ctrl.sv
// Turns PIO commit toggles into single-cycle framebuffer RAM writes, buffered
// through a small FIFO while the refresh logic holds the RAM.
module fb_write_ctrl
    import fb_pkg::*;
#(
    parameter int unsigned ADDR_W     = FB_ADDR_W,
    parameter int unsigned DATA_W     = FB_DATA_W,
    parameter int unsigned FB_WORDS   = 4096,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] wr_addr_in,
    input  logic [DATA_W-1:0] wr_data_in,
    input  logic [2:0]        wr_ctrl_in,
    input  logic              ram_gnt,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [31:0]       status
);

    localparam int unsigned       LVL_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] PTR_MAX = ADDR_W'(FB_WORDS - 1);

    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] a);
        return (a == PTR_MAX) ? '0 : a + 1'b1;
    endfunction

    logic              init_q;
    logic [2:0]        hist_q;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              ovf_q, ovf_d;
    logic [15:0]       cnt_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;

    logic              commit, ptr_load, ovf_clr, auto_inc;
    logic              fifo_full, fifo_empty, pop, push_ok, drop;
    logic [LVL_W-1:0]  fifo_level;
    logic [ADDR_W-1:0] cmd_addr;
    fb_cmd_t           push_cmd, head_cmd;

    // Edge events are masked on the init cycle so a level held through reset is not an event.
    always_comb begin
        auto_inc = wr_ctrl_in[CTRL_AUTOINC];
        commit   = !init_q && (wr_ctrl_in[CTRL_COMMIT] != hist_q[CTRL_COMMIT]);
        ptr_load = !init_q && wr_ctrl_in[CTRL_AUTOINC] && !hist_q[CTRL_AUTOINC];
        ovf_clr  = !init_q && wr_ctrl_in[CTRL_OVFCLR] && !hist_q[CTRL_OVFCLR];
        pop      = !fifo_empty && ram_gnt;
        push_ok  = commit && (!fifo_full || pop);
        drop     = commit && !push_ok;
        // A pointer load takes priority: the coincident commit uses the new address.
        cmd_addr = (auto_inc && !ptr_load) ? ptr_q : wr_addr_in;
        push_cmd.addr = cmd_addr;
        push_cmd.data = wr_data_in;
    end

    // Pointer and sticky overflow next-state; a drop beats a coincident clear.
    always_comb begin
        ptr_d = ptr_q;
        ovf_d = ovf_q;
        if (ptr_load)               ptr_d = push_ok ? ptr_inc(wr_addr_in) : wr_addr_in;
        else if (push_ok && auto_inc) ptr_d = ptr_inc(ptr_q);
        if (drop)         ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
    end

    fb_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_ok),
        .wdata   (push_cmd),
        .pop     (pop),
        .rdata   (head_cmd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Control history, pointer, overflow, write counter and registered RAM port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_q      <= 1'b1;
            hist_q      <= '0;
            ptr_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            init_q   <= 1'b0;
            hist_q   <= wr_ctrl_in;
            ptr_q    <= ptr_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_q + 16'(ram_we_q);
            ram_we_q <= pop;
            if (pop) begin
                ram_addr_q  <= head_cmd.addr;
                ram_wdata_q <= head_cmd.data;
            end
        end
    end

    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

    // Status readback word assembled from registered state.
    always_comb begin
        status = '0;
        status[STAT_WRCNT_LSB +: STAT_WRCNT_W] = cnt_q;
        status[STAT_LEVEL_LSB +: STAT_LEVEL_W] = 3'(fifo_level);
        status[STAT_BUSY]                      = (fifo_level != '0) || ram_we_q;
        status[STAT_OVF]                       = ovf_q;
    end

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Self-checking bench for fb_write_ctrl: directed scenarios followed by random
// traffic, all compared every cycle against a queue-based reference model.
module tb_fb_write_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] wr_addr_in;
    logic [23:0] wr_data_in;
    logic [2:0]  wr_ctrl_in;
    logic        ram_gnt;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [23:0] ram_wdata;
    logic [31:0] status;

    fb_write_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_addr_in (wr_addr_in),
        .wr_data_in (wr_data_in),
        .wr_ctrl_in (wr_ctrl_in),
        .ram_gnt    (ram_gnt),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .status     (status)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [35:0] m_q[$];
    logic        m_init;
    logic [2:0]  m_hist;
    logic [11:0] m_ptr;
    logic        m_ovf;
    logic [15:0] m_cnt;
    logic        m_we;
    logic [11:0] m_waddr;
    logic [23:0] m_wdata;

    logic [11:0] wlog[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_q.delete();
        m_init  = 1'b1;
        m_hist  = 3'b000;
        m_ptr   = '0;
        m_ovf   = 1'b0;
        m_cnt   = '0;
        m_we    = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
    endtask

    function automatic logic [11:0] wrap_inc(input logic [11:0] a);
        return 12'((int'(a) + 1) % 4096);
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s = '0;
        s[20]    = m_ovf;
        s[19]    = (m_q.size() != 0) || m_we;
        s[18:16] = 3'(m_q.size());
        s[15:0]  = m_cnt;
        return s;
    endfunction

    // Advance the model by one clock using the current inputs, clock the DUT, compare.
    task automatic tick();
        if (reset_n) begin
            logic        c0, ld, clr, pop, acc;
            logic [11:0] a;
            c0  = !m_init && (wr_ctrl_in[0] != m_hist[0]);
            ld  = !m_init && wr_ctrl_in[1] && !m_hist[1];
            clr = !m_init && wr_ctrl_in[2] && !m_hist[2];
            pop = (m_q.size() != 0) && ram_gnt;
            acc = c0 && ((m_q.size() < 4) || pop);
            a   = (wr_ctrl_in[1] && !ld) ? m_ptr : wr_addr_in;
            m_cnt = m_cnt + 16'(m_we);
            m_we  = pop;
            if (pop) {m_waddr, m_wdata} = m_q.pop_front();
            if (acc) m_q.push_back({a, wr_data_in});
            if (ld)                        m_ptr = acc ? wrap_inc(wr_addr_in) : wr_addr_in;
            else if (acc && wr_ctrl_in[1]) m_ptr = wrap_inc(m_ptr);
            if (c0 && !acc) m_ovf = 1'b1;
            else if (clr)   m_ovf = 1'b0;
            m_hist = wr_ctrl_in;
            m_init = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("ram_we", 32'(ram_we), 32'(m_we));
        chk("status", status, m_status());
        if (m_we) begin
            chk("ram_addr", 32'(ram_addr), 32'(m_waddr));
            chk("ram_wdata", 32'(ram_wdata), 32'(m_wdata));
        end
        if (ram_we) wlog.push_back(ram_addr);
    endtask

    task automatic toggle();
        wr_ctrl_in[0] = ~wr_ctrl_in[0];
    endtask

    initial begin
        reset_n    = 1'b0;
        wr_ctrl_in = 3'b001;
        ram_gnt    = 1'b1;
        wr_addr_in = '0;
        wr_data_in = '0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_we", 32'(ram_we), 32'd0);
        chk("reset_status", status, 32'd0);

        // Release with commit bit already high: no spurious write.
        reset_n = 1'b1;
        repeat (10) begin
            tick();
            chk("init_no_we", 32'(ram_we), 32'd0);
        end
        chk("init_status", status, 32'd0);

        // Single direct-address write, latency T+2.
        wr_addr_in = 12'h123;
        wr_data_in = 24'hFF8000;
        toggle();
        tick();
        chk("lat_t1_we", 32'(ram_we), 32'd0);
        tick();
        chk("lat_t2_we", 32'(ram_we), 32'd1);
        chk("lat_addr", 32'(ram_addr), 32'h123);
        chk("lat_data", 32'(ram_wdata), 32'hFF8000);
        tick();
        chk("lat_t3_we", 32'(ram_we), 32'd0);
        chk("wr_count1", 32'(status[15:0]), 32'd1);

        // Auto-increment wrap.
        wlog.delete();
        wr_addr_in    = 12'hFFE;
        wr_ctrl_in[1] = 1'b1;
        tick();
        repeat (3) begin
            toggle();
            tick();
            tick();
        end
        repeat (3) tick();
        chk("wrap_n", 32'(wlog.size()), 32'd3);
        if (wlog.size() == 3) begin
            chk("wrap_a0", 32'(wlog[0]), 32'hFFE);
            chk("wrap_a1", 32'(wlog[1]), 32'hFFF);
            chk("wrap_a2", 32'(wlog[2]), 32'h000);
        end

        // Overflow with stalled RAM.
        wlog.delete();
        wr_ctrl_in[1] = 1'b0;
        ram_gnt       = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_addr_in = 12'(12'h010 + i);
            wr_data_in = 24'(24'hA00000 + i);
            toggle();
            tick();
        end
        chk("ovf_level", 32'(status[18:16]), 32'd4);
        chk("ovf_flag", 32'(status[20]), 32'd1);
        chk("ovf_busy", 32'(status[19]), 32'd1);
        ram_gnt = 1'b1;
        repeat (8) tick();
        chk("ovf_n", 32'(wlog.size()), 32'd4);
        for (int i = 0; i < 4 && i < wlog.size(); i++)
            chk("ovf_order", 32'(wlog[i]), 32'(12'h010 + i));
        chk("ovf_count", 32'(status[15:0]), 32'd8);

        // Overflow clear, then clear coinciding with a drop.
        wr_ctrl_in[2] = 1'b1;
        tick();
        chk("clr_flag", 32'(status[20]), 32'd0);
        wr_ctrl_in[2] = 1'b0;
        ram_gnt       = 1'b0;
        repeat (4) begin
            toggle();
            tick();
        end
        toggle();
        wr_ctrl_in[2] = 1'b1;
        tick();
        chk("clr_drop_flag", 32'(status[20]), 32'd1);
        wr_ctrl_in[2] = 1'b0;
        ram_gnt       = 1'b1;
        repeat (8) tick();

        // Asynchronous reset with entries pending and a write in flight.
        ram_gnt = 1'b0;
        repeat (4) begin
            toggle();
            tick();
        end
        ram_gnt = 1'b1;
        tick();
        chk("mid_we_pre", 32'(ram_we), 32'd1);
        chk("mid_level_pre", 32'(status[18:16]), 32'd3);
        reset_n = 1'b0;
        #1;
        chk("mid_we_async", 32'(ram_we), 32'd0);
        chk("mid_status_async", status, 32'd0);
        m_reset();
        repeat (2) tick();
        reset_n = 1'b1;
        wlog.delete();
        repeat (10) tick();
        chk("mid_no_writes", 32'(wlog.size()), 32'd0);
        chk("mid_level", 32'(status[18:16]), 32'd0);

        // Random traffic with varying grant density.
        for (int blk = 0; blk < 8; blk++) begin
            int gnt_pct;
            gnt_pct = $urandom_range(10, 100);
            for (int c = 0; c < 50; c++) begin
                ram_gnt    = ($urandom_range(0, 99) < gnt_pct);
                wr_addr_in = 12'($urandom);
                wr_data_in = 24'($urandom);
                if ($urandom_range(0, 1) == 0)  wr_ctrl_in[0] = ~wr_ctrl_in[0];
                if ($urandom_range(0, 15) == 0) wr_ctrl_in[1] = ~wr_ctrl_in[1];
                if ($urandom_range(0, 7) == 0)  wr_ctrl_in[2] = ~wr_ctrl_in[2];
                tick();
            end
        end
        ram_gnt = 1'b1;
        repeat (8) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fb_write_ctrl.md
Name: fb_write_ctrl

Overview:
- Consumes the 12-bit framebuffer write address PIO output, plus companion data and control PIO outputs, and turns software commits into single-cycle writes on the LED panel framebuffer RAM write port.
- Buffers commits in a small FIFO so software is not stalled when the panel refresh logic holds the RAM (ram_gnt low).
- Supports an auto-increment address mode for streaming pixel writes.
- Exposes a status word for a readback PIO.

Parameters:
- ADDR_W, 12, framebuffer address width; matches the write-address PIO width.
- DATA_W, 24, pixel word width (RGB 8:8:8).
- FB_WORDS, 4096, number of framebuffer words; the auto-increment pointer wraps at FB_WORDS-1. Must be <= 2^ADDR_W.
- FIFO_DEPTH, 4, commit FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- wr_addr_in  in  ADDR_W  address from the write-address PIO out_port.
- wr_data_in  in  DATA_W  pixel data from the data PIO.
- wr_ctrl_in  in  3  control PIO: [0] commit toggle, [1] auto_inc enable, [2] overflow clear.
- ram_gnt  in  1  RAM write port available this cycle.
- ram_we  out  1  write enable, one-cycle pulse per word.
- ram_addr  out  ADDR_W  write address, valid when ram_we=1.
- ram_wdata  out  DATA_W  write data, valid when ram_we=1.
- status  out  32  {11'b0, overflow[20], busy[19], fifo_level[18:16], wr_count[15:0]}.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: ram_we=0, ram_addr=0, ram_wdata=0, status=0. FIFO is flushed, pointer=0, overflow=0, wr_count=0. All wr_ctrl_in edge-detect history registers are 0, and the init flag is set.
- Init cycle: the first clk edge after reset release loads the history registers from wr_ctrl_in without generating any event, then clears init. This prevents a spurious commit when bit0=1 at reset release.
- Commit event: wr_ctrl_in[0] differs from its history value. Each change is exactly one commit, on either a 0->1 or 1->0 transition.
- Commit address:
  - auto_inc=0: wr_addr_in in the event cycle.
  - auto_inc=1: the pointer value. The pointer increments after each accepted commit and wraps FB_WORDS-1 -> 0.
- Pointer load: a 0->1 transition of wr_ctrl_in[1] loads the pointer from wr_addr_in.
- Load with commit in the same cycle: if the bit1 0->1 transition and a commit occur together, the commit uses wr_addr_in and the pointer becomes wr_addr_in+1, wrapping as above.
- Push: {addr, wr_data_in} is written into the FIFO at the end of the event cycle.
- Full FIFO:
  - A commit is dropped when the FIFO is full and no pop happens that cycle. A dropped commit sets overflow (sticky), and the pointer does not advance.
  - Simultaneous push and pop when full: both occur and nothing is dropped.
- Pop: when fifo_level>0 and ram_gnt=1, the head entry is popped. No bypass exists, so a push into an empty FIFO cannot pop in the same cycle.
- RAM write outputs: registered. A pop in cycle N gives ram_we=1 with that entry's addr/data in cycle N+1. ram_we is 0 otherwise, and ram_addr/ram_wdata hold their last values.
- Latency: a commit toggle first visible in cycle T gives ram_we in cycle T+2 when the FIFO is empty and ram_gnt=1. Each cycle ram_gnt is low delays the write by one cycle.
- Write ordering: writes leave in commit order.
- wr_count: increments by 1 on each ram_we and wraps at 16 bits.
- overflow clear: cleared on a 0->1 transition of wr_ctrl_in[2]. If a drop occurs in the same cycle as the clear, set wins.
- busy = (fifo_level != 0) | ram_we.
- status: combinational from registers.
- Reset mid-operation: pending FIFO entries are discarded, and an in-flight ram_we is deasserted immediately (asynchronous).

Decomposition:
- Shared package fb_pkg:
  - CTRL_COMMIT=0, CTRL_AUTOINC=1, CTRL_OVFCLR=2.
  - Status field bit positions.
  - Typedef fb_cmd_t = struct {addr[ADDR_W], data[DATA_W]}.
- One sub-module, fb_cmd_fifo: a synchronous FIFO of FIFO_DEPTH fb_cmd_t entries.
  - Interface: push, pop, full, empty, level.
  - Behaviour: simultaneous push and pop allowed when full; async active-low reset.
- Edge detection, pointer, overflow and output registers live in fb_write_ctrl.

Test Plan:
- Reset release with wr_ctrl_in=3'b001 -> no ram_we for 10 cycles; status=0.
- auto_inc=0, ram_gnt=1, addr=0x123, data=0xFF8000, toggle bit0 at T -> ram_we at T+2 only, ram_addr=0x123, ram_wdata=0xFF8000; wr_count=1.
- Auto-increment wrap:
  - Stimulus: addr=0xFFE; bit1 0->1; then 3 toggles spaced 2 cycles apart with ram_gnt=1.
  - Required: writes to 0xFFE, 0xFFF, 0x000.
- Overflow with stalled RAM:
  - Stimulus: ram_gnt=0; 5 toggles on consecutive cycles, addr=0x010..0x014.
  - Required: fifo_level=4, overflow=1, busy=1.
  - Then ram_gnt=1: writes 0x010..0x013 in order, 0x014 absent, wr_count=4.
- overflow clear:
  - Stimulus: bit2 0->1.
  - Required: overflow=0 next cycle.
  - Clear in the same cycle as a drop: overflow stays 1.
- Reset mid-operation: assert reset_n=0 with 3 entries pending and ram_we=1 -> ram_we=0 immediately; after release no writes occur and fifo_level=0.
